// File: rtl/dmem_arb_pkg.sv
// Shared defaults and state encoding for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner
);

    assign winner = (req0 && req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two ports fixed-latency access to one
// single-ported data memory (IDLE -> SERVE -> ACK per transaction).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t                    state;
    state_t                    state_nxt;
    logic                      load;
    logic                      winner;
    logic                      last_grant;
    logic                      lat_id;
    logic                      lat_we;
    logic [ADDR_W-1:0]         lat_addr;
    logic signed [DATA_W-1:0]  lat_wdata;

    rr_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // Control state; last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_grant <= winner;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    load      = 1'b1;
                    state_nxt = SERVE;
                end
            end
            SERVE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction capture; only observed through state-gated outputs.
    always_ff @(posedge clock) begin
        if (load) begin
            lat_id    <= winner;
            lat_we    <= winner ? we1 : we0;
            lat_addr  <= winner ? addr1 : addr0;
            lat_wdata <= winner ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (state == SERVE && !lat_we) begin
            rdata <= mem_rdata;
        end
    end

    // Outputs decode from state, so an asynchronous reset drops them at once.
    assign busy      = (state != IDLE);
    assign gnt0      = busy && !lat_id;
    assign gnt1      = busy && lat_id;
    assign ack0      = (state == ACK) && !lat_id;
    assign ack1      = (state == ACK) && lat_id;
    assign mem_write = (state == SERVE) && lat_we;
    assign mem_read  = (state == SERVE) && !lat_we;
    assign mem_addr  = (state == SERVE) ? lat_addr : '0;
    assign mem_wdata = (state == SERVE) ? lat_wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-write memory model.
module tb_dmem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [DW-1:0] rdata;
    logic          mem_write, mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    bit overlap = 1'b0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always @(negedge clock) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    always @(negedge clock) if (gnt0 && gnt1) overlap = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = v; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = v; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One single-port transaction starting from IDLE, checked cycle by cycle.
    task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                       input bit chk_rd);
        set_req(p, 1'b1, w, a, d);
        tick;
        check("serve_gnt",   (p == 1) ? gnt1 : gnt0, 1);
        check("serve_other", (p == 1) ? gnt0 : gnt1, 0);
        check("serve_wr",    mem_write, w);
        check("serve_rd",    mem_read, !w);
        check("serve_addr",  mem_addr, a);
        if (w) check("serve_wdata", mem_wdata, d);
        tick;
        check("ack_own",     (p == 1) ? ack1 : ack0, 1);
        check("ack_other",   (p == 1) ? ack0 : ack1, 0);
        check("ack_wr_low",  mem_write, 0);
        if (chk_rd) check("ack_rdata", rdata, exp_rd);
        set_req(p, 1'b0, 1'b0, '0, '0);
        tick;
        check("idle_busy",   busy, 0);
        check("idle_ack",    ack0 | ack1, 0);
    endtask

    initial begin
        logic [3:0] order;
        int         n;
        int         acks;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[9] = 32'h0000_0123;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Reset values
        tick;
        tick;
        check("rst_busy",  busy, 0);
        check("rst_gnt",   {gnt1, gnt0}, 0);
        check("rst_ack",   {ack1, ack0}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem",   {mem_write, mem_read}, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_mwd",   mem_wdata, 0);

        // Port 0 write -7 to addr 5, then read it back
        reset = 1'b0;
        txn(0, 1'b1, 13'd5, 32'hFFFF_FFF9, '0, 1'b0);
        check("mem5", mem[5], 32'hFFFF_FFF9);
        txn(0, 1'b0, 13'd5, '0, 32'hFFFF_FFF9, 1'b1);

        // Simultaneous requests after reset: port 0 first, then port 1
        reset = 1'b1;
        tick;
        reset = 1'b0;
        set_req(0, 1'b1, 1'b0, 13'd9, '0);
        set_req(1, 1'b1, 1'b0, 13'd5, '0);
        tick;
        check("tie_gnt0",   gnt0, 1);
        check("tie_gnt1",   gnt1, 0);
        check("tie_addr0",  mem_addr, 9);
        tick;
        check("tie_ack0",   {ack1, ack0}, 2'b01);
        check("tie_rd0",    rdata, 32'h0000_0123);
        req0 = 1'b0;
        tick;
        check("tie_idle",   busy, 0);
        tick;
        check("tie2_gnt",   {gnt1, gnt0}, 2'b10);
        check("tie2_addr",  mem_addr, 5);
        tick;
        check("tie2_ack",   {ack1, ack0}, 2'b10);
        check("tie2_rd",    rdata, 32'hFFFF_FFF9);
        req1 = 1'b0;
        tick;

        // Continuous contention for 12 cycles
        set_req(0, 1'b1, 1'b0, 13'd9, '0);
        set_req(1, 1'b1, 1'b0, 13'd5, '0);
        order = '0;
        n = 0;
        repeat (12) begin
            tick;
            if (ack0 || ack1) begin
                if (n < 4) order[n] = ack1;
                n++;
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("alt_count", n, 4);
        check("alt_order", order, 4'b1010);
        tick;
        check("alt_idle",  busy, 0);

        // Port 1 boundary address, read held across a later write
        txn(1, 1'b1, 13'd8191, 32'h7FFF_FFFF, '0, 1'b0);
        check("mem8191", mem[8191], 32'h7FFF_FFFF);
        txn(1, 1'b0, 13'd8191, '0, 32'h7FFF_FFFF, 1'b1);
        txn(0, 1'b1, 13'd3, 32'h0000_1234, 32'h7FFF_FFFF, 1'b1);
        tick;
        check("rd_held",   rdata, 32'h7FFF_FFFF);

        // Port 0 drops req during SERVE
        set_req(0, 1'b1, 1'b0, 13'd3, '0);
        tick;
        check("drop_gnt",  gnt0, 1);
        req0 = 1'b0;
        tick;
        check("drop_ack",  ack0, 1);
        check("drop_rd",   rdata, 32'h0000_1234);
        tick;
        tick;
        check("drop_nogr", {busy, gnt0}, 0);

        // Reset in the middle of a SERVE write to 8191
        set_req(1, 1'b1, 1'b1, 13'd8191, 32'hDEAD_BEEF);
        tick;
        check("abort_wr",   mem_write, 1);
        reset = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        check("abort_wr0",  mem_write, 0);
        check("abort_busy", busy, 0);
        check("abort_gnt",  gnt1, 0);
        check("abort_rd",   rdata, 0);
        check("abort_addr", mem_addr, 0);
        tick;
        tick;
        reset = 1'b0;
        acks = 0;
        repeat (4) begin
            tick;
            if (ack0 || ack1 || busy) acks++;
        end
        check("abort_noack", acks, 0);
        check("abort_mem",   mem[8191], 32'h7FFF_FFFF);

        // Tie after that reset goes to port 0 again
        set_req(0, 1'b1, 1'b0, 13'd9, '0);
        set_req(1, 1'b1, 1'b0, 13'd5, '0);
        tick;
        check("post_tie",  {gnt1, gnt0}, 2'b01);
        tick;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick;

        check("gnt_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, data memory word-address width (8192 words).
REQ-002 SHALL have parameter DATA_W, default 32, signed data word width.
REQ-003 SHALL have port clock  input  1  single system clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  per-port transaction request, held until that port's ack.
REQ-006 SHALL have ports we0/we1  input  1  per-port write(1)/read(0) select, valid while req high.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  per-port word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  per-port write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  port owns memory (SERVE and ACK states).
REQ-010 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rdata  output  DATA_W  read result, valid in the ack cycle, held until the next read completes.
REQ-012 SHALL have ports mem_write, mem_read  output  1  memory write and read enables.
REQ-013 SHALL have ports mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-014 SHALL have port mem_rdata  input  DATA_W  combinational read data from memory.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SERVE, ACK; encoding from the shared package.
REQ-017 IDLE: if any req is high at posedge, SHALL latch the winner's id, we, addr, wdata and go to SERVE; otherwise stay in IDLE.
REQ-018 Winner SHALL be round-robin: single requester wins; with req0 and req1 both high, the port opposite last_grant wins.
REQ-019 last_grant SHALL update to the winner on the IDLE->SERVE transition only.
REQ-020 SERVE (exactly one cycle): mem_addr/mem_wdata SHALL drive the latched values; mem_write = latched we; mem_read = not latched we.
REQ-021 mem_write SHALL be high for the full SERVE cycle so the memory's negedge write lands mid-cycle; it SHALL be low in all other states.
REQ-022 At the SERVE->ACK posedge, a read SHALL capture mem_rdata into rdata; a write SHALL leave rdata unchanged.
REQ-023 ACK (exactly one cycle): SHALL assert ack of the owning port only, then return to IDLE.
REQ-024 Latency SHALL be fixed: request sampled in IDLE at cycle N, ack at cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-025 req SHALL be sampled only in IDLE; req changes in SERVE/ACK SHALL be ignored; req still high in the IDLE after ACK is a new request.
REQ-026 With both ports continuously requesting, grants SHALL strictly alternate 0,1,0,1...
REQ-027 gnt0/gnt1 SHALL be one-hot or zero, never both high; all outputs SHALL be registered or decoded from state only.
REQ-028 Address SHALL be passed unmodified (no wrap or offset); out-of-range values cannot occur at ADDR_W bits.

Reset
REQ-029 Reset assertion SHALL immediately force state IDLE, last_grant = 1 (port 0 wins first), and all outputs to 0, including rdata, mem_* and busy.
REQ-030 Reset during SERVE SHALL drop mem_write asynchronously; the aborted transaction SHALL never ack; no replay after release.
REQ-031 The first request SHALL be sampled at the first posedge after reset deasserts.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the ADDR_W/DATA_W defaults and the state enum typedef.
REQ-033 The two-way round-robin pick SHALL be sub-module rr_pick2 (inputs req0, req1, last_grant; output winner id), purely combinational.
REQ-034 Target size SHALL be 120-250 RTL lines, no memory array inside the block.

Verification
REQ-035 Port 0 write addr 5, data -7, then port 0 read addr 5 -> ack0 at N+2 each; rdata = -7 (0xFFFFFFF9); mem_write high only in the first SERVE.
REQ-036 req0 and req1 high in the same cycle after reset -> port 0 served first, port 1 next; gnt never overlaps.
REQ-037 Both ports requesting for 12 cycles -> 4 acks alternating ack0,ack1,ack0,ack1.
REQ-038 Reset asserted mid-SERVE of write to addr 8191 -> mem_write falls immediately, no ack, memory word 8191 unchanged.
REQ-039 Port 1 read addr 8191 following port 1 write 0x7FFFFFFF there -> rdata = 0x7FFFFFFF, held through later writes.
REQ-040 Port 0 drops req during SERVE -> transaction still completes with ack0; no new grant while req0 stays low.
